// File: rtl/bram_loader_pkg.sv
// Shared types and constants for the byte-stream to 32-bit block RAM loader.
// Holds the FSM state encoding, frame constants and the running checksum helper.
package bram_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_CHK    = 3'd5
  } state_t;

  localparam logic [7:0] SYNC_BYTE      = 8'hA5;
  localparam int         LEN_BYTES      = 2;
  localparam int         BYTES_PER_WORD = 4;

  // Frame checksum is the XOR of every payload byte.
  function automatic logic [7:0] chk_update(input logic [7:0] chk, input logic [7:0] b);
    return chk ^ b;
  endfunction

endpackage

// File: rtl/bram_loader.sv
// Receives framed bytes (sync, 16-bit word count, payload, XOR checksum) and
// writes the payload as little-endian 32-bit words into a block RAM from address 0.
module bram_loader
  import bram_loader_pkg::*;
#(
  parameter int         adr_width = 11,
  parameter logic [7:0] sync_byte = SYNC_BYTE
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [31:0] ram_do,
  output logic        ram_we,
  output logic [15:0] ram_a,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [16:0] MAX_WORDS = 17'd1 << (adr_width - 2);

  state_t      state_r, state_s;
  logic [15:0] len_r, len_s;
  logic [1:0]  byte_cnt_r, byte_cnt_s;
  logic [15:0] word_cnt_r, word_cnt_s;
  logic [31:0] data_r, data_s;
  logic [15:0] addr_r, addr_s;
  logic [7:0]  chk_r, chk_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        err_r, err_s;
  logic        we_r, we_s;
  logic        rdy_r, rdy_s;
  logic        accept_s;
  logic [15:0] frame_len_s;
  logic [15:0] words_done_s;

  assign accept_s     = rx_valid && rdy_r;
  assign frame_len_s  = {len_r[15:8], rx_data};
  assign words_done_s = word_cnt_r + 16'd1;

  assign rx_ready = rdy_r;
  assign ram_do   = data_r;
  assign ram_we   = we_r;
  assign ram_a    = addr_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;

  // Next-state and next-register values; ready/write-enable are registered so
  // the WRITE cycle shows ram_we=1 and rx_ready=0 together.
  always_comb begin
    state_s    = state_r;
    len_s      = len_r;
    byte_cnt_s = byte_cnt_r;
    word_cnt_s = word_cnt_r;
    data_s     = data_r;
    addr_s     = addr_r;
    chk_s      = chk_r;
    busy_s     = busy_r;
    done_s     = done_r;
    err_s      = err_r;
    we_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && (rx_data == sync_byte)) begin
          state_s    = ST_LEN_HI;
          len_s      = 16'd0;
          byte_cnt_s = 2'd0;
          word_cnt_s = 16'd0;
          addr_s     = 16'd0;
          chk_s      = 8'd0;
          busy_s     = 1'b1;
          done_s     = 1'b0;
          err_s      = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LEN_HI: begin
        if (accept_s) begin
          len_s   = {rx_data, 8'h00};
          state_s = ST_LEN_LO;
        end else begin
          state_s = ST_LEN_HI;
        end
      end
      ST_LEN_LO: begin
        if (accept_s) begin
          len_s = frame_len_s;
          if ({1'b0, frame_len_s} > MAX_WORDS) begin
            state_s = ST_IDLE;
            busy_s  = 1'b0;
            done_s  = 1'b1;
            err_s   = 1'b1;
          end else if (frame_len_s == 16'd0) begin
            state_s = ST_CHK;
          end else begin
            state_s = ST_DATA;
          end
        end else begin
          state_s = ST_LEN_LO;
        end
      end
      ST_DATA: begin
        if (accept_s) begin
          case (byte_cnt_r)
            2'd0:    data_s[7:0]   = rx_data;
            2'd1:    data_s[15:8]  = rx_data;
            2'd2:    data_s[23:16] = rx_data;
            2'd3:    data_s[31:24] = rx_data;
            default: data_s        = data_r;
          endcase
          chk_s      = chk_update(chk_r, rx_data);
          byte_cnt_s = byte_cnt_r + 2'd1;
          if (byte_cnt_r == 2'd3) begin
            state_s = ST_WRITE;
            we_s    = 1'b1;
          end else begin
            state_s = ST_DATA;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_WRITE: begin
        addr_s     = addr_r + 16'd4;
        word_cnt_s = words_done_s;
        if (words_done_s < len_r) begin
          state_s = ST_DATA;
        end else begin
          state_s = ST_CHK;
        end
      end
      ST_CHK: begin
        if (accept_s) begin
          state_s = ST_IDLE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          err_s   = (rx_data != chk_r);
        end else begin
          state_s = ST_CHK;
        end
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase
    rdy_s = (state_s != ST_WRITE);
  end

  // FSM state register.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      len_r      <= 16'd0;
      byte_cnt_r <= 2'd0;
      word_cnt_r <= 16'd0;
      data_r     <= 32'd0;
      addr_r     <= 16'd0;
      chk_r      <= 8'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      we_r       <= 1'b0;
      rdy_r      <= 1'b1;
    end else begin
      len_r      <= len_s;
      byte_cnt_r <= byte_cnt_s;
      word_cnt_r <= word_cnt_s;
      data_r     <= data_s;
      addr_r     <= addr_s;
      chk_r      <= chk_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      err_r      <= err_s;
      we_r       <= we_s;
      rdy_r      <= rdy_s;
    end
  end

endmodule

// File: tb/tb_bram_loader.sv
// Directed frames for bram_loader; expected RAM writes go into a scoreboard
// queue that a monitor drains whenever ram_we is seen.
module tb_bram_loader;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [15:0] a;
    logic [31:0] d;
  } wr_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] ram_do;
  logic        ram_we;
  logic [15:0] ram_a;
  logic        busy;
  logic        done;
  logic        err;

  wr_t exp_q[$];
  int  checks   = 0;
  int  fails    = 0;
  int  ready_lo = 0;
  bit  mon_en   = 1'b0;

  bram_loader dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .ram_do  (ram_do),
    .ram_we  (ram_we),
    .ram_a   (ram_a),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the head of the scoreboard.
  always @(negedge sys_clk) begin
    if (mon_en) begin
      if (!rx_ready) ready_lo++;
      check("we_vs_ready", {31'd0, ram_we}, {31'd0, ~rx_ready});
      if (ram_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_write: got %h @%h expected no write", ram_do, ram_a);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", {16'd0, ram_a}, {16'd0, e.a});
          check("wr_data", ram_do, e.d);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit acc;
    bit ok;
    ok       = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      acc = rx_ready;
      @(posedge sys_clk);
      #1;
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: got no acceptance expected byte %h taken", b);
    end
  endtask

  task automatic send_seq(input byte_q_t s);
    foreach (s[i]) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic push_wr(input logic [15:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic push_frame_a();
    push_wr(16'h0000, 32'h44332211);
    push_wr(16'h0004, 32'hEFBEADDE);
  endtask

  initial begin
    byte_q_t body_a;
    body_a   = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    sys_rst  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(posedge sys_clk);
    #1;
    check("rst_we",   {31'd0, ram_we}, 32'd0);
    check("rst_do",   ram_do, 32'd0);
    check("rst_a",    {16'd0, ram_a}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err",  {31'd0, err}, 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    mon_en  = 1'b1;
    @(posedge sys_clk);
    #1;
    check("ready_after_rst", {31'd0, rx_ready}, 32'd1);

    // Garbage then frame A with continuous valid
    push_frame_a();
    ready_lo = 0;
    send_seq('{8'h00, 8'hFF, 8'h5A});
    check("garbage_busy", {31'd0, busy}, 32'd0);
    send_byte(8'hA5);
    check("sync_busy", {31'd0, busy}, 32'd1);
    send_seq(body_a);
    send_byte(8'h66);
    check("a_done", {31'd0, done}, 32'd1);
    check("a_err",  {31'd0, err}, 32'd0);
    check("a_busy", {31'd0, busy}, 32'd0);
    check("a_ready_low_cycles", ready_lo, 32'd2);
    check("a_queue_empty", exp_q.size(), 32'd0);
    idle(2);

    // Frame A with bad checksum: writes stay, err set
    push_frame_a();
    send_byte(8'hA5);
    send_seq(body_a);
    send_byte(8'h00);
    check("bad_done", {31'd0, done}, 32'd1);
    check("bad_err",  {31'd0, err}, 32'd1);
    check("bad_queue_empty", exp_q.size(), 32'd0);
    idle(2);

    // Empty frame; sync clears the previous err
    send_byte(8'hA5);
    check("sync_clr_done", {31'd0, done}, 32'd0);
    check("sync_clr_err",  {31'd0, err}, 32'd0);
    send_seq('{8'h00, 8'h00, 8'h00});
    check("n0_done", {31'd0, done}, 32'd1);
    check("n0_err",  {31'd0, err}, 32'd0);
    idle(2);

    // Oversized length 513
    send_seq('{8'hA5, 8'h02, 8'h01});
    check("big_done", {31'd0, done}, 32'd1);
    check("big_err",  {31'd0, err}, 32'd1);
    check("big_busy", {31'd0, busy}, 32'd0);
    send_seq('{8'h11, 8'h22, 8'h33, 8'h44});
    idle(3);
    check("big_queue_empty", exp_q.size(), 32'd0);

    // Reset mid-frame, then a full frame from address 0
    send_seq('{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22});
    sys_rst = 1'b0;
    #1;
    check("mid_rst_we",   {31'd0, ram_we}, 32'd0);
    check("mid_rst_do",   ram_do, 32'd0);
    check("mid_rst_a",    {16'd0, ram_a}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_err",  {31'd0, err}, 32'd0);
    rx_valid = 1'b0;
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    check("ready_after_mid_rst", {31'd0, rx_ready}, 32'd1);
    send_seq('{8'h33, 8'h44});
    check("post_rst_idle_busy", {31'd0, busy}, 32'd0);
    push_frame_a();
    send_byte(8'hA5);
    send_seq(body_a);
    send_byte(8'h66);
    check("rst_frame_done", {31'd0, done}, 32'd1);
    check("rst_frame_err",  {31'd0, err}, 32'd0);

    // Back-to-back: bad frame, then one-word frame with a sync value in payload
    push_frame_a();
    push_wr(16'h0000, 32'h030201A5);
    send_byte(8'hA5);
    send_seq(body_a);
    send_byte(8'h00);
    check("b2b1_err", {31'd0, err}, 32'd1);
    send_byte(8'hA5);
    check("b2b_sync_done", {31'd0, done}, 32'd0);
    check("b2b_sync_err",  {31'd0, err}, 32'd0);
    check("b2b_sync_busy", {31'd0, busy}, 32'd1);
    send_seq('{8'h00, 8'h01, 8'hA5, 8'h01, 8'h02, 8'h03, 8'hA5});
    check("b2b2_done", {31'd0, done}, 32'd1);
    check("b2b2_err",  {31'd0, err}, 32'd0);
    idle(4);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/bram_loader.md
BRAM_LOADER -- requirements
Module: bram_loader

Interface
REQ-001 Parameter adr_width, default 11, meaning RAM byte-address width, matching the downstream 32-bit block RAM.
REQ-002 Parameter sync_byte, default 8'hA5, meaning frame start marker.
REQ-003 sys_clk  in  1  single clock; all logic rising-edge.
REQ-004 sys_rst  in  1  asynchronous, active-low reset.
REQ-005 rx_data  in  8  incoming byte (from UART receiver).
REQ-006 rx_valid  in  1  rx_data valid.
REQ-007 rx_ready  out  1  loader accepts byte; transfer when rx_valid && rx_ready.
REQ-008 ram_do  out  32  write data to RAM "do" port.
REQ-009 ram_we  out  1  RAM write enable.
REQ-010 ram_a  out  16  RAM byte address, always word-aligned (bits [1:0] = 0).
REQ-011 busy  out  1  high from sync-byte acceptance until frame end.
REQ-012 done  out  1  sticky, frame finished.
REQ-013 err  out  1  sticky, frame failed (checksum or length).

Function
REQ-014 Frame format SHALL be: sync_byte, LEN_HI, LEN_LO (16-bit word count N, big-endian), 4*N payload bytes, one checksum byte.
REQ-015 FSM states SHALL be IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHK.
REQ-016 IDLE: bytes other than sync_byte SHALL be accepted and discarded; sync_byte -> LEN_HI, clears done/err, sets busy.
REQ-017 LEN_HI -> LEN_LO on accepted byte; LEN_LO -> DATA if N>0, -> CHK if N=0.
REQ-018 N > 2^(adr_width-2) (default 512) SHALL set done=1, err=1, busy=0, return to IDLE; no RAM write issued.
REQ-019 DATA: payload bytes SHALL be packed little-endian (1st byte -> ram_do[7:0], 4th -> [31:24]) using a 2-bit byte counter.
REQ-020 On acceptance of the 4th byte in cycle T, state SHALL be WRITE in cycle T+1 with ram_we=1 for exactly that one cycle, ram_do and ram_a stable.
REQ-021 rx_ready SHALL be 1 in every state except WRITE, where it is 0.
REQ-022 After WRITE, ram_a SHALL advance by 4; next state DATA if words written < N, else CHK.
REQ-023 Word index SHALL wrap at 16 bits only; ram_a starts at 0 for every frame.
REQ-024 Checksum SHALL be XOR of all 4*N payload bytes (0x00 when N=0).
REQ-025 CHK: accepted byte equal to checksum -> done=1, err=0; unequal -> done=1, err=1; both -> busy=0, IDLE, in the cycle after acceptance.
REQ-026 Writes already performed SHALL NOT be undone on checksum failure.
REQ-027 sync_byte values inside LEN/DATA/CHK SHALL be treated as ordinary data.
REQ-028 ram_we SHALL never be asserted outside WRITE.

Reset
REQ-029 sys_rst=0 SHALL force, asynchronously: state IDLE, ram_we=0, ram_do=0, ram_a=0, busy=0, done=0, err=0, counters and checksum 0.
REQ-030 Reset mid-frame SHALL abandon the frame; after release, loader waits for a new sync_byte.
REQ-031 rx_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-032 Shared package bram_loader_pkg SHALL hold the FSM state typedef and the default SYNC_BYTE and frame-header constants.
REQ-033 Single module, no sub-module; output ports connect directly to bram32 do/we/a with adr_width equal on both.

Verification
REQ-034 Frame A5 00 02 11 22 33 44 DE AD BE EF <chk=0x66> -> writes 0x44332211 @0x0000, 0xEFBEADDE @0x0004, done=1, err=0.
REQ-035 Same frame with checksum 0x00 -> same two writes, done=1, err=1.
REQ-036 Frame A5 00 00 00 -> no write, done=1, err=0; A5 02 01 .. (N=513) -> no write, done=1, err=1.
REQ-037 Leading garbage 00 FF 5A then valid frame -> garbage ignored, frame loads normally; rx_valid held high continuously -> rx_ready low exactly one cycle per word.
REQ-038 sys_rst pulsed low after 2nd payload byte -> ram_we=0 immediately, outputs 0; following full frame loads from 0x0000.
REQ-039 Back-to-back frames: done/err of frame 1 cleared on frame 2 sync byte; ram_a restarts at 0.
